// File: rtl/volume_ctrl.sv
// Digital volume attenuator: a saturating attenuation level stepped by up/down
// controls, applied to each sample as an unsigned logical right shift.
module volume_ctrl #(
  parameter int width_p       = 24,
  parameter int shift_min_p   = 1,
  parameter int shift_max_p   = 7,
  parameter int shift_reset_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] sound_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] sound_o
);

  localparam int level_w_lp = $clog2(shift_max_p + 1);

  localparam logic [level_w_lp-1:0] level_min_lp   = level_w_lp'(shift_min_p);
  localparam logic [level_w_lp-1:0] level_max_lp   = level_w_lp'(shift_max_p);
  localparam logic [level_w_lp-1:0] level_reset_lp = level_w_lp'(shift_reset_p);

  // Encoding matches the {up_i, down_i} concatenation bit-for-bit.
  typedef enum logic [1:0] {
    cmd_hold = 2'b00,
    cmd_down = 2'b01,
    cmd_up   = 2'b10,
    cmd_both = 2'b11
  } cmd_e;

  cmd_e                  cmd;
  logic [level_w_lp-1:0] level_r;
  logic [level_w_lp-1:0] level_n;

  assign cmd = cmd_e'({up_i, down_i});

  always_comb begin
    // NOTE: default assigned first so every path through the case drives
    // level_n; a missing branch would otherwise infer a latch.
    level_n = level_r;
    unique case (cmd)
      cmd_up:   if (level_r < level_max_lp) level_n = level_r + 1'b1;
      cmd_down: if (level_r > level_min_lp) level_n = level_r - 1'b1;
      cmd_hold,
      cmd_both: level_n = level_r;
      default:  level_n = level_r;
    endcase
  end

  // Reset is synchronous and overrides any up/down request on the same edge.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignment for state so every flop samples the
    // pre-edge values regardless of process ordering.
    if (!reset_i) level_r <= level_reset_lp;
    else          level_r <= level_n;
  end

  assign sound_o = sound_i >> level_r;

endmodule

// File: tb/tb_volume_ctrl.sv
// Self-checking bench for volume_ctrl: a level model predicts each attenuated
// sample, expectations are queued as stimulus is driven and popped on sampling.
module tb_volume_ctrl;

  localparam int width_lp = 24;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [width_lp-1:0] sound_i;
  logic                up_i;
  logic                down_i;
  logic [width_lp-1:0] sound_o;

  logic [width_lp-1:0] exp_q[$];
  int                  model_level;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  volume_ctrl #(
    .width_p      (width_lp),
    .shift_min_p  (1),
    .shift_max_p  (7),
    .shift_reset_p(3)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .sound_i(sound_i),
    .up_i   (up_i),
    .down_i (down_i),
    .sound_o(sound_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [width_lp-1:0] got,
                       input logic [width_lp-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h (model level %0d)", tag, got, exp, model_level);
    end
  endtask

  // Drive a sample (no edge involved), queue its expectation, then compare.
  task automatic probe(input string tag, input logic [width_lp-1:0] snd);
    logic [width_lp-1:0] exp;
    sound_i = snd;
    exp_q.push_back(snd >> model_level);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, sound_o, exp);
    end
  endtask

  // One clock: controls applied before the edge, model updated at the edge,
  // then the given sample plus an all-ones probe that exposes the level.
  task automatic step(input string tag, input logic rst, input logic up,
                      input logic dn, input logic [width_lp-1:0] snd);
    @(negedge clk_i);
    reset_i = rst;
    up_i    = up;
    down_i  = dn;
    @(posedge clk_i);
    if (!rst)                           model_level = 3;
    else if (up && !dn && model_level < 7) model_level++;
    else if (dn && !up && model_level > 1) model_level--;
    #1;
    probe(tag, snd);
    probe({tag, "_lvl"}, 24'hFFFFFF);
  endtask

  initial begin
    reset_i     = 1'b0;
    up_i        = 1'b0;
    down_i      = 1'b0;
    sound_i     = '0;
    model_level = 3;

    // Reset held several cycles, then a nonzero sample while still in reset.
    for (int i = 0; i < 3; i++) step("rst_zero", 1'b0, 1'b0, 1'b0, 24'h000000);
    probe("rst_sample", 24'h000010);

    // Step down to the floor and saturate there.
    step("down_3to2", 1'b1, 1'b0, 1'b1, 24'h000002);
    step("down_2to1", 1'b1, 1'b0, 1'b1, 24'h000002);
    step("down_floor", 1'b1, 1'b0, 1'b1, 24'h000002);

    // Up once, then a simultaneous press is ignored.
    step("up_1to2", 1'b1, 1'b1, 1'b0, 24'h000004);
    step("both_hold", 1'b1, 1'b1, 1'b1, 24'h000004);

    // Held up for six cycles saturates at the ceiling.
    for (int i = 0; i < 6; i++) step("up_hold", 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
    step("idle_ceil", 1'b1, 1'b0, 1'b0, 24'hFFFFFF);

    // Alternate down/up at the ceiling with an incrementing sample.
    for (int i = 0; i < 8; i++)
      step("alt", 1'b1, i[0], ~i[0], 24'h123456 + width_lp'(i));

    // Reset mid-run overrides an up request.
    step("rst_mid", 1'b0, 1'b1, 1'b0, 24'hABCDEF);
    step("rst_mid_dn", 1'b0, 1'b0, 1'b1, 24'h800000);
    step("post_rst", 1'b1, 1'b0, 1'b0, 24'h00FF00);

    // Random controls and samples against the model.
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom),
           width_lp'($urandom));

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
